// File: rtl/if_stage.sv
// Instruction-fetch stage with pre-IF PC generation: drives the inst SRAM, holds {inst, pc}, hands it to decode.
// Optional macro IF_ADEF_EN: flags misaligned fetch addresses as exceptions and widens the bus by an excp bit.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int BR_BUS_WD = 33,
`ifdef IF_ADEF_EN
  parameter int FS_TO_DS_BUS_WD = 65
`else
  parameter int FS_TO_DS_BUS_WD = 64
`endif
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_en,
  output logic                       inst_sram_we,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic [31:0]                inst_sram_rdata
);

  logic        br_taken;
  logic [31:0] br_target;
  logic        to_fs_valid;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic        inst_buf_valid;
  logic [31:0] inst_buf;
  logic [31:0] buf_din;
  logic [31:0] fs_inst;

  assign br_taken  = br_bus[BR_BUS_WD-1];
  assign br_target = br_bus[31:0];

  assign seq_pc      = fs_pc + 32'd4;
  assign nextpc      = br_taken ? br_target : seq_pc;
  assign fs_ready_go = 1'b1;
  assign fs_allowin  = ~fs_valid | (fs_ready_go & ds_allowin) | br_taken;

  // A taken branch in decode means the instruction in IF is wrong-path.
  assign fs_to_ds_valid = fs_valid & ~br_taken;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_fs_valid <= 1'b0;
    end else begin
      to_fs_valid <= 1'b1;
    end
  end

`ifdef IF_ADEF_EN
  logic adef_next;
  logic fs_excp;

  assign adef_next    = nextpc[1:0] != 2'b00;
  assign inst_sram_en = to_fs_valid & fs_allowin & ~adef_next;
  assign buf_din      = fs_excp ? 32'h0 : inst_sram_rdata;
  assign fs_inst      = fs_excp ? 32'h0 : (inst_buf_valid ? inst_buf : inst_sram_rdata);
  assign fs_to_ds_bus = {fs_excp, fs_inst, fs_pc};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fs_excp <= 1'b0;
    end else if (fs_allowin && to_fs_valid) begin
      fs_excp <= adef_next;
    end
  end
`else
  assign inst_sram_en = to_fs_valid & fs_allowin;
  assign buf_din      = inst_sram_rdata;
  assign fs_inst      = inst_buf_valid ? inst_buf : inst_sram_rdata;
  assign fs_to_ds_bus = {fs_inst, fs_pc};
`endif

  assign inst_sram_we    = 1'b0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'h0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fs_valid <= 1'b0;
      fs_pc    <= RESET_PC - 32'd4;
    end else if (fs_allowin) begin
      fs_valid <= to_fs_valid;
      if (to_fs_valid) begin
        fs_pc <= nextpc;
      end
    end
  end

  // SRAM output is not held while en=0, so the first stall cycle's data is parked here.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_buf_valid <= 1'b0;
      inst_buf       <= 32'h0;
    end else if (br_taken || (fs_to_ds_valid && ds_allowin)) begin
      inst_buf_valid <= 1'b0;
    end else if (fs_valid && !ds_allowin && !inst_buf_valid) begin
      inst_buf_valid <= 1'b1;
      inst_buf       <= buf_din;
    end
  end

endmodule
